// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and types for the 16-bit pipelined CPU.
package cpu_pkg;
  localparam logic [3:0]  HLT_OPCODE = 4'hF;
  localparam logic [15:0] NOP_INSTR  = 16'h0000;
  localparam logic [15:0] RESET_PC   = 16'h0000;
  typedef enum logic [0:0] {RUN = 1'b0, HALTED = 1'b1} fetch_state_e;
  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
    logic        valid;
  } if_id_t;
  localparam if_id_t IF_ID_BUBBLE = '{pc: 16'h0000, instr: NOP_INSTR, valid: 1'b0};
endpackage

// File: rtl/fetch_stage.sv
// fetch_stage: PC, instruction-memory read port and IF/ID register with stall, redirect and halt.
module fetch_stage
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [15:0] redirect_pc_i,
  output logic [15:0] im_addr_o,
  output logic        im_rd_en_o,
  input  logic [15:0] im_instr_i,
  output logic [15:0] if_id_pc_o,
  output logic [15:0] if_id_instr_o,
  output logic        if_id_valid_o,
  output logic        halted_o
);
  logic [15:0]  pc;
  logic [15:0]  pc_next;
  if_id_t       if_id;
  fetch_state_e state;
  logic         is_hlt;
  assign pc_next       = pc + 16'd1;
  assign is_hlt        = im_instr_i[15:12] == HLT_OPCODE;
  assign im_addr_o     = pc;
  assign im_rd_en_o    = (state == RUN) && !stall_i;
  assign if_id_pc_o    = if_id.pc;
  assign if_id_instr_o = if_id.instr;
  assign if_id_valid_o = if_id.valid;
  assign halted_o      = state == HALTED;
  // Redirect beats stall; halt detection only applies to real fetches in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      if_id <= IF_ID_BUBBLE;
      state <= RUN;
    end else if (redirect_i) begin
      pc    <= redirect_pc_i;
      if_id <= IF_ID_BUBBLE;
      state <= RUN;
    end else if (!stall_i) begin
      if (state == RUN) begin
        if_id <= '{pc: pc_next, instr: im_instr_i, valid: 1'b1};
        if (is_hlt) state <= HALTED;
        else pc <= pc_next;
      end else begin
        if_id <= IF_ID_BUBBLE;
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage against a simple instruction-memory image.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_i;
  logic [15:0] redirect_pc_i;
  logic [15:0] im_addr_o;
  logic        im_rd_en_o;
  logic [15:0] im_instr_i;
  logic [15:0] if_id_pc_o;
  logic [15:0] if_id_instr_o;
  logic        if_id_valid_o;
  logic        halted_o;
  logic [15:0] hlt_addr;
  int          n_cmp = 0;
  int          n_bad = 0;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .im_addr_o(im_addr_o), .im_rd_en_o(im_rd_en_o),
    .im_instr_i(im_instr_i), .if_id_pc_o(if_id_pc_o), .if_id_instr_o(if_id_instr_o),
    .if_id_valid_o(if_id_valid_o), .halted_o(halted_o)
  );

  always #5 clk = ~clk;

  // Memory image: word at address a is 16'h1000+a, except a single HLT at hlt_addr.
  assign im_instr_i = (im_addr_o == hlt_addr) ? 16'hF000 : 16'h1000 + im_addr_o;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_if(input string tag, input logic [15:0] pc, input logic [15:0] instr,
                        input logic valid);
    chk({tag, ".pc"}, if_id_pc_o, pc);
    chk({tag, ".instr"}, if_id_instr_o, instr);
    chk({tag, ".valid"}, {15'd0, if_id_valid_o}, {15'd0, valid});
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".addr"}, im_addr_o, 16'h0000);
    chk({tag, ".rd_en"}, {15'd0, im_rd_en_o}, 16'd1);
    chk({tag, ".halted"}, {15'd0, halted_o}, 16'd0);
    chk_if(tag, 16'h0000, 16'h0000, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 16'h0000;
    hlt_addr = 16'h0007;
    #2 chk_reset("reset");
    @(negedge clk) rst_n = 1'b1;
    step(); chk_if("run0", 16'h0001, 16'h1000, 1'b1);
    step(); chk_if("run1", 16'h0002, 16'h1001, 1'b1);
    step(); chk_if("run2", 16'h0003, 16'h1002, 1'b1);
    step(); step();
    chk_if("pre_stall", 16'h0005, 16'h1004, 1'b1);
    chk("pre_stall.addr", im_addr_o, 16'h0005);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_if("stall", 16'h0005, 16'h1004, 1'b1);
      chk("stall.addr", im_addr_o, 16'h0005);
      chk("stall.rd_en", {15'd0, im_rd_en_o}, 16'd0);
    end
    stall_i = 1'b0;
    step(); chk_if("post_stall", 16'h0006, 16'h1005, 1'b1);
    chk("post_stall.addr", im_addr_o, 16'h0006);
    step(); chk_if("pre_hlt", 16'h0007, 16'h1006, 1'b1);
    step(); chk_if("hlt", 16'h0008, 16'hF000, 1'b1);
    chk("hlt.halted", {15'd0, halted_o}, 16'd1);
    chk("hlt.addr", im_addr_o, 16'h0007);
    chk("hlt.rd_en", {15'd0, im_rd_en_o}, 16'd0);
    step(); chk_if("halted_bubble", 16'h0000, 16'h0000, 1'b0);
    chk("halted_bubble.halted", {15'd0, halted_o}, 16'd1);
    chk("halted_bubble.addr", im_addr_o, 16'h0007);
    redirect_i = 1'b1; redirect_pc_i = 16'h0020;
    step(); redirect_i = 1'b0;
    chk("resume.halted", {15'd0, halted_o}, 16'd0);
    chk("resume.addr", im_addr_o, 16'h0020);
    chk("resume.rd_en", {15'd0, im_rd_en_o}, 16'd1);
    chk_if("resume_bubble", 16'h0000, 16'h0000, 1'b0);
    step(); chk_if("resume_fetch", 16'h0021, 16'h1020, 1'b1);
    redirect_i = 1'b1; redirect_pc_i = 16'h0040; stall_i = 1'b1;
    step(); redirect_i = 1'b0; stall_i = 1'b0;
    chk("redir_stall.addr", im_addr_o, 16'h0040);
    chk_if("redir_stall_bubble", 16'h0000, 16'h0000, 1'b0);
    step(); chk_if("redir_fetch", 16'h0041, 16'h1040, 1'b1);
    redirect_i = 1'b1; redirect_pc_i = 16'hFFFF;
    step(); redirect_i = 1'b0;
    chk("wrap_pre.addr", im_addr_o, 16'hFFFF);
    step(); chk("wrap.addr", im_addr_o, 16'h0000);
    chk_if("wrap", 16'h0000, 16'h0FFF, 1'b1);
    step(); chk_if("wrap_next", 16'h0001, 16'h1000, 1'b1);
    step();
    redirect_i = 1'b1; redirect_pc_i = 16'h0100;
    #2 rst_n = 1'b0;
    #1 chk_reset("async_reset");
    @(negedge clk) begin redirect_i = 1'b0; rst_n = 1'b1; end
    chk_reset("after_reset");
    step(); chk_if("restart", 16'h0001, 16'h1000, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 16-bit five-stage pipelined CPU. Owns the program counter, drives the instruction-memory read port, and produces the IF/ID pipeline register consumed by decode. It applies hazard stalls, squashes the wrong-path instruction on a branch redirect from EX/MEM, and stops fetching once a halt instruction has been fetched.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- HLT_OPCODE, 4'hF, opcode (instr[15:12]) that halts fetch
- NOP_INSTR, 16'h0000, instruction word inserted as a bubble
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- stall_i  in  1  hazard unit: hold PC and IF/ID this cycle
- redirect_i  in  1  taken branch/jump resolved in EX/MEM
- redirect_pc_i  in  16  target PC, valid when redirect_i=1
- im_addr_o  out  16  instruction-memory address, equals current PC
- im_rd_en_o  out  1  instruction-memory read enable
- im_instr_i  in  16  instruction word at im_addr_o, combinational, same cycle
- if_id_pc_o  out  16  PC+1 of the instruction held in IF/ID
- if_id_instr_o  out  16  instruction held in IF/ID
- if_id_valid_o  out  1  1 = real instruction, 0 = bubble
- halted_o  out  1  1 while in HALTED state

## Operation
- State machine: RUN, HALTED. Reset → RUN.
- PC is word-addressed; increment is +1, modulo 2^16 (16'hFFFF → 16'h0000).
- im_addr_o = pc always; im_rd_en_o = (state==RUN) & ~stall_i.
- Per-cycle priority: redirect_i > stall_i > halt detection > normal fetch.
- Redirect (either state): pc ← redirect_pc_i; IF/ID ← bubble (instr=NOP_INSTR, valid=0, pc=0); state ← RUN. Overrides stall_i.
- Stall (no redirect): pc, IF/ID and state hold unchanged.
- RUN, no stall/redirect, im_instr_i[15:12] != HLT_OPCODE: IF/ID ← {pc+1, im_instr_i, valid=1}; pc ← pc+1.
- RUN, no stall/redirect, im_instr_i[15:12] == HLT_OPCODE: IF/ID ← {pc+1, im_instr_i, valid=1}; pc holds; state ← HALTED.
- HALTED, no stall/redirect: pc holds; IF/ID ← bubble each cycle so the HLT drains downstream.
- Redirect while HALTED handles a halt fetched on a wrong path; fetch resumes at the target.
- Bubbles never cause a halt: detection looks at im_instr_i only in RUN.

## Timing
- Reset values: pc=RESET_PC, im_addr_o=RESET_PC, im_rd_en_o=1, if_id_pc_o=0, if_id_instr_o=NOP_INSTR, if_id_valid_o=0, halted_o=0.
- Fetch latency: instruction at PC p is presented in cycle t and appears on if_id_* after edge t+1.
- Redirect asserted in cycle t: target is presented on im_addr_o in cycle t+1, and its instruction is in IF/ID after edge t+2. Exactly one bubble is inserted.
- Stall of n cycles holds all outputs for n cycles; fetch resumes on the first non-stalled edge with no lost or duplicated instruction.
- halted_o rises the edge the HLT enters IF/ID and falls the edge a redirect is taken.
- Reset mid-operation takes effect immediately (asynchronous) and discards any pending redirect or halt.

## Structure
- Shared package cpu_pkg holds: opcode constants including HLT_OPCODE, NOP_INSTR, RESET_PC, the fetch state enum, and the IF/ID record type {pc, instr, valid}.
- No sub-module. The PC register, IF/ID register and two-state FSM live in one block.

## Test plan
- Reset then free-run over memory 16'h1000,16'h1001,16'h1002: if_id_instr 1000/1001/1002 with if_id_pc 1/2/3 on consecutive cycles, valid=1.
- stall_i high for 3 cycles while IF/ID holds instr at pc 5: outputs frozen for 3 cycles, im_rd_en_o=0; next instruction is pc 6, with no duplicate.
- redirect_i with redirect_pc_i=16'h0040 while stall_i=1: next cycle im_addr_o=0040 and IF/ID is a bubble; the following cycle IF/ID holds mem[0040] with if_id_pc=0041.
- HLT (16'hF000) at pc 7: IF/ID gets F000/pc 8, halted_o=1, pc stays 7, IF/ID shows bubbles afterwards, im_rd_en_o=0.
- While HALTED, redirect_i to 16'h0020: halted_o=0, fetch resumes at 0020.
- PC preset to 16'hFFFF via redirect: after one fetch im_addr_o=16'h0000 and if_id_pc_o=16'h0000. Assert rst_n low mid-stream: all outputs take their reset values immediately.
